key_debounce: RTL and testbench
===============================

# key_debounce

Multi-key debouncer and press-event generator that sits directly upstream of the LED drivers. It takes raw, active-low push-button inputs on the 12 MHz board clock and delivers clean, debounced key levels. It also produces single-cycle press, release and long-press pulses, which the LED stages use as mode and enable controls. Per key, it runs a synchroniser, an integrating debounce counter and a small hold-state FSM.

## Interface
- `KEY_NUM`, default 4: number of independent keys.
- `CLK_FREQ`, default 12_000_000: `clk_in` frequency in Hz.
- `DEBOUNCE_MS`, default 20: stable time required before a level change is accepted.
- `LONG_MS`, default 1000: hold time that qualifies a long press.
- Derived `DEB_CNT = CLK_FREQ/1000*DEBOUNCE_MS` and `LONG_CNT = CLK_FREQ/1000*LONG_MS`. Both must be ≥ 2. Counter widths are `$clog2` of each.
- `clk_in`, input, 1: system clock, 12 MHz.
- `rst_n_in`, input, 1: reset, asynchronous, active-low.
- `key_n_in`, input, `KEY_NUM`: raw buttons, active-low, asynchronous to `clk_in`.
- `key_state`, output, `KEY_NUM`: debounced level, 1 = pressed.
- `key_press`, output, `KEY_NUM`: 1-cycle pulse when `key_state` rises.
- `key_release`, output, `KEY_NUM`: 1-cycle pulse when `key_state` falls.
- `key_long`, output, `KEY_NUM`: 1-cycle pulse when a press has lasted `LONG_CNT` cycles.

## Operation
- **Synchroniser:** each key uses a 2-flop synchroniser on the inverted input, giving `sync2` with 1 = pressed. Its reset value is 0 (released).
- **Debounce counter:** each key has a counter `deb_cnt`.
  - If `sync2 == key_state`, then `deb_cnt <= 0`.
  - Otherwise `deb_cnt` increments.
  - When `deb_cnt == DEB_CNT-1` and `sync2` still differs, `key_state` toggles and `deb_cnt <= 0` on the same edge.
- **Glitches:** any glitch shorter than `DEB_CNT` consecutive cycles clears the count. Such a glitch never reaches `key_state`.
- **Edge pulses:** `key_press` and `key_release` are registered alongside the `key_state` toggle. They are high for exactly the cycle in which the new `key_state` is first visible.
- **Hold FSM, per key:**
  - `IDLE`: on a `key_state` rise go to `HELD`, with `hold_cnt <= 0`.
  - `HELD`: `hold_cnt` increments each cycle. At `hold_cnt == LONG_CNT-1`, pulse `key_long` and go to `LONG`. On a `key_state` fall go to `IDLE`.
  - `LONG`: there is no further `key_long` pulse, so auto-repeat is not supported. On a `key_state` fall go to `IDLE`.
- **Release after long press:** `key_release` still fires on the release that follows a long press.
- **Independence:** keys are fully independent, and simultaneous events on different keys are each reported in their own bit.
- **Release on the long-press cycle:** if the release toggle and `hold_cnt == LONG_CNT-1` coincide, the release wins. `key_long` is not pulsed and the FSM goes to `IDLE`.

## Timing
- **Reset:** all outputs are 0. The `sync` flops, `deb_cnt`, `hold_cnt` and the FSMs (`IDLE`) are cleared asynchronously.
- **Reset mid-operation:** a reset during debounce or hold discards all progress. After reset, a key that is still held must pass `DEB_CNT` cycles again and then produces a fresh `key_press`.
- **Debounce latency:** let edge k be the edge at which `sync1` captures a new level. `key_state`, `key_press` and `key_release` update at edge k+1+`DEB_CNT`, provided the input stayed stable throughout.
- **Long-press latency:** `key_long` is high `LONG_CNT` cycles after the `key_press` cycle.
- **Pulse width:** every pulse is exactly 1 cycle wide, and there are no back-to-back pulses on the same bit within `DEB_CNT` cycles.

## Configuration
- `KEY_LONG_PRESS_EN` defined: the hold FSM and `hold_cnt` are built, and `key_long` behaves as above.
- `KEY_LONG_PRESS_EN` undefined: no hold logic is generated and `key_long` is tied to 0. `key_state`, `key_press` and `key_release` behave identically.
- The port list is the same in both builds.

## Test plan
All scenarios use `CLK_FREQ=1000`, `DEBOUNCE_MS=4` (giving `DEB_CNT=4`), `LONG_MS=20` (giving `LONG_CNT=20`), `KEY_NUM=4`, and `KEY_LONG_PRESS_EN` defined.
- **Clean press:** drive `key_n_in[0]` low at edge k → `key_state[0]` = 1 and `key_press[0]` = 1 at edge k+5. `key_press[0]` is 0 again at edge k+6.
- **Bounce:** toggle `key_n_in[1]` low/high every 2 cycles for 20 cycles, then hold it high → `key_state[1]`, `key_press[1]` and `key_release[1]` stay 0 throughout.
- **Long press:** hold `key_n_in[2]` low for 40 cycles, then release.
  - Expect exactly one `key_long[2]` pulse, 20 cycles after `key_press[2]`.
  - Expect one `key_release[2]` 5 edges after the release.
- **Short press:** hold `key_n_in[3]` low for 10 cycles → one `key_press[3]` and one `key_release[3]`, with no `key_long[3]` pulse.
- **Simultaneous keys, then reset:** press keys 0 and 3 on the same edge → both `key_press` bits pulse in the same cycle. Then assert `rst_n_in` low for 2 cycles mid-hold → all outputs go to 0 immediately. After reset is released with the keys still held, a new `key_press` appears 5 edges later.
- **Macro off:** rebuild with `KEY_LONG_PRESS_EN` undefined and repeat the long-press scenario → `key_long` stays 0, while press and release timing is unchanged.

Source files
------------

// File: rtl/key_debounce.sv
// key_debounce: multi-key synchroniser, integrating debouncer and press/release/long-press pulse generator.
// Optional long-press hold logic is built only when KEY_LONG_PRESS_EN is defined; otherwise key_long is tied to 0.
module key_debounce #(
    parameter int KEY_NUM     = 4,
    parameter int CLK_FREQ    = 12_000_000,
    parameter int DEBOUNCE_MS = 20,
    parameter int LONG_MS     = 1000
) (
    input  logic               clk_in,
    input  logic               rst_n_in,
    input  logic [KEY_NUM-1:0] key_n_in,
    output logic [KEY_NUM-1:0] key_state,
    output logic [KEY_NUM-1:0] key_press,
    output logic [KEY_NUM-1:0] key_release,
    output logic [KEY_NUM-1:0] key_long
);
    localparam int DEB_CNT  = CLK_FREQ / 1000 * DEBOUNCE_MS;
    localparam int LONG_CNT = CLK_FREQ / 1000 * LONG_MS;
    localparam int DEB_W    = $clog2(DEB_CNT);
    localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEB_CNT - 1);
`ifdef KEY_LONG_PRESS_EN
    localparam int LONG_W = $clog2(LONG_CNT);
    localparam logic [LONG_W-1:0] LONG_MAX = LONG_W'(LONG_CNT - 1);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] HELD = 2'd1;
    localparam logic [1:0] LONG = 2'd2;
`endif

    if (DEB_CNT < 2 || LONG_CNT < 2) begin : g_bad_cfg
        $error("key_debounce: DEB_CNT and LONG_CNT must both be at least 2");
    end

    genvar g;
    for (g = 0; g < KEY_NUM; g = g + 1) begin : g_key
        logic             sync1_q, sync2_q;
        logic             state_q, state_d;
        logic             press_q, press_d;
        logic             release_q, release_d;
        logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
        logic             toggle;

        // Accept a new level only after it has disagreed with key_state for DEB_CNT consecutive cycles
        always_comb begin
            toggle    = (sync2_q != state_q) && (deb_cnt_q == DEB_MAX);
            deb_cnt_d = (sync2_q == state_q || toggle) ? '0 : deb_cnt_q + 1'b1;
            state_d   = state_q ^ toggle;
            press_d   = toggle & ~state_q;
            release_d = toggle & state_q;
        end

        // Synchroniser on the inverted raw key, debounce count and registered level/edge outputs
        always_ff @(posedge clk_in or negedge rst_n_in) begin
            if (!rst_n_in) begin
                sync1_q   <= 1'b0;
                sync2_q   <= 1'b0;
                deb_cnt_q <= '0;
                state_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                sync1_q   <= ~key_n_in[g];
                sync2_q   <= sync1_q;
                deb_cnt_q <= deb_cnt_d;
                state_q   <= state_d;
                press_q   <= press_d;
                release_q <= release_d;
            end
        end

        assign key_state[g]   = state_q;
        assign key_press[g]   = press_q;
        assign key_release[g] = release_q;

`ifdef KEY_LONG_PRESS_EN
        logic [1:0]        fsm_q, fsm_d;
        logic [LONG_W-1:0] hold_cnt_q, hold_cnt_d;
        logic              long_q, long_d;

        // Hold FSM: a release always wins, even on the cycle the long-press count would expire
        always_comb begin
            fsm_d      = fsm_q;
            hold_cnt_d = hold_cnt_q;
            long_d     = 1'b0;
            if (release_d) begin
                fsm_d = IDLE;
            end else if (press_d) begin
                fsm_d      = HELD;
                hold_cnt_d = '0;
            end else if (fsm_q == HELD) begin
                if (hold_cnt_q == LONG_MAX) begin
                    long_d = 1'b1;
                    fsm_d  = LONG;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
        end

        // Hold state, hold counter and the single long-press pulse
        always_ff @(posedge clk_in or negedge rst_n_in) begin
            if (!rst_n_in) begin
                fsm_q      <= IDLE;
                hold_cnt_q <= '0;
                long_q     <= 1'b0;
            end else begin
                fsm_q      <= fsm_d;
                hold_cnt_q <= hold_cnt_d;
                long_q     <= long_d;
            end
        end

        assign key_long[g] = long_q;
`else
        assign key_long[g] = 1'b0;
`endif
    end
endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: table-driven, directed and randomized checks of key_debounce against a windowed reference model.
module tb_key_debounce;
    localparam int K   = 4;
    localparam int DEB = 4;
    localparam int LNG = 20;
`ifdef KEY_LONG_PRESS_EN
    localparam bit LONG_EN = 1'b1;
`else
    localparam bit LONG_EN = 1'b0;
`endif

    logic         clk_in = 1'b0;
    logic         rst_n_in;
    logic [K-1:0] key_n_in;
    logic [K-1:0] key_state, key_press, key_release, key_long;

    key_debounce #(
        .KEY_NUM    (K),
        .CLK_FREQ   (1000),
        .DEBOUNCE_MS(DEB),
        .LONG_MS    (LNG)
    ) dut (
        .clk_in     (clk_in),
        .rst_n_in   (rst_n_in),
        .key_n_in   (key_n_in),
        .key_state  (key_state),
        .key_press  (key_press),
        .key_release(key_release),
        .key_long   (key_long)
    );

    always #5 clk_in = ~clk_in;

    int n_cmp = 0;
    int n_bad = 0;
    int n     = 0;

    // Reference model: per key, a history of raw samples taken at each edge (h[0] newest).
    // The synchronised level seen at edge n is the raw sample of edge n-2, so a level is accepted
    // when the DEB synchronised samples h[DEB+1:2] all disagree with the accepted state and no
    // acceptance (or reset) happened within the last DEB edges.
    logic [DEB+1:0] h [K];
    int             last_acc [K];
    int             press_at [K];
    logic [K-1:0]   m_state, m_press, m_rel, m_long;
    logic [K-1:0]   seen_press, seen_rel, seen_long;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, n);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < K; k++) begin
            h[k]        = '0;
            last_acc[k] = n;
            press_at[k] = -100000;
        end
        m_state = '0;
        m_press = '0;
        m_rel   = '0;
        m_long  = '0;
    endtask

    task automatic model_step();
        logic tog;
        for (int k = 0; k < K; k++) begin
            h[k]       = {h[k][DEB:0], ~key_n_in[k]};
            tog        = (h[k][DEB+1:2] == {DEB{~m_state[k]}}) && (n - last_acc[k] >= DEB);
            m_press[k] = tog & ~m_state[k];
            m_rel[k]   = tog & m_state[k];
            if (tog) begin
                m_state[k]  = ~m_state[k];
                last_acc[k] = n;
            end
            if (m_press[k]) press_at[k] = n;
            m_long[k] = LONG_EN && m_state[k] && (n - press_at[k] == LNG);
        end
    endtask

    task automatic compare_all(input string tag);
        chk({tag, ".state"},   key_state,   m_state);
        chk({tag, ".press"},   key_press,   m_press);
        chk({tag, ".release"}, key_release, m_rel);
        chk({tag, ".long"},    key_long,    m_long);
    endtask

    task automatic tick();
        @(posedge clk_in);
        n++;
        if (!rst_n_in) model_reset();
        else model_step();
        #1;
        compare_all("model");
        seen_press |= key_press;
        seen_rel   |= key_release;
        seen_long  |= key_long;
    endtask

    task automatic apply_reset();
        rst_n_in = 1'b0;
        model_reset();
        #1;
        chk("reset_async.outputs", {key_state, key_press, key_release, key_long}, 32'h0);
        tick();
        tick();
        rst_n_in = 1'b1;
    endtask

    typedef struct {
        logic [K-1:0] key_n;
        int           cycles;
        logic [K-1:0] press;
        logic [K-1:0] rel;
        logic [K-1:0] lng;
        logic [K-1:0] state;
    } row_t;

    row_t rows[$];
    int   lat;
    int   rem [K];
    logic [K-1:0] kv;

    initial begin
        rst_n_in = 1'b0;
        key_n_in = '1;
        seen_press = '0;
        seen_rel   = '0;
        seen_long  = '0;
        model_reset();
        tick();
        tick();
        chk("reset_state", {key_state, key_press, key_release, key_long}, 32'h0);
        rst_n_in = 1'b1;

        rows.push_back('{4'hE, 10, 4'b0001, 4'b0000, 4'b0000, 4'b0001});
        rows.push_back('{4'hF, 10, 4'b0000, 4'b0001, 4'b0000, 4'b0000});
        for (int i = 0; i < 10; i++)
            rows.push_back('{(i % 2 == 0) ? 4'hD : 4'hF, 2, 4'b0000, 4'b0000, 4'b0000, 4'b0000});
        rows.push_back('{4'hF, 10, 4'b0000, 4'b0000, 4'b0000, 4'b0000});
        rows.push_back('{4'hB, 40, 4'b0100, 4'b0000, LONG_EN ? 4'b0100 : 4'b0000, 4'b0100});
        rows.push_back('{4'hF, 10, 4'b0000, 4'b0100, 4'b0000, 4'b0000});
        rows.push_back('{4'h7, 10, 4'b1000, 4'b0000, 4'b0000, 4'b1000});
        rows.push_back('{4'hF, 10, 4'b0000, 4'b1000, 4'b0000, 4'b0000});
        rows.push_back('{4'h6, 8,  4'b1001, 4'b0000, 4'b0000, 4'b1001});

        foreach (rows[i]) begin
            key_n_in   = rows[i].key_n;
            seen_press = '0;
            seen_rel   = '0;
            seen_long  = '0;
            repeat (rows[i].cycles) tick();
            chk($sformatf("row%0d.press", i),   seen_press, rows[i].press);
            chk($sformatf("row%0d.release", i), seen_rel,   rows[i].rel);
            chk($sformatf("row%0d.long", i),    seen_long,  rows[i].lng);
            chk($sformatf("row%0d.state", i),   key_state,  rows[i].state);
        end

        // Reset while keys 0 and 3 are held: progress is discarded and a fresh press follows
        apply_reset();
        lat = 0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (key_press != 0) begin
                lat = i;
                break;
            end
        end
        chk("reset_repress.latency", lat, 1 + 1 + DEB);
        chk("reset_repress.bits", key_press, 4'b1001);
        key_n_in = '1;
        repeat (10) tick();

        // Clean press latency and pulse width on key 0
        key_n_in = 4'hE;
        lat = 0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (key_press[0]) begin
                lat = i;
                break;
            end
        end
        chk("press.latency", lat, 1 + 1 + DEB);
        tick();
        chk("press.width", key_press[0], 1'b0);
        key_n_in = '1;
        repeat (10) tick();

        // Long press on key 2: long pulse LNG cycles after press, release still reported
        key_n_in = 4'hB;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (key_press[2]) break;
        end
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (key_long[2]) begin
                lat = i;
                break;
            end
        end
        chk("long.latency", lat, LONG_EN ? LNG : 0);
        repeat (5) tick();
        key_n_in = '1;
        lat = 0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (key_release[2]) begin
                lat = i;
                break;
            end
        end
        chk("long.release_latency", lat, 1 + 1 + DEB);
        repeat (10) tick();

        // Randomized per-key hold durations mixing glitches, short presses and long presses
        kv = '1;
        for (int k = 0; k < K; k++) rem[k] = $urandom_range(1, 10);
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < K; k++) begin
                if (rem[k] == 0) begin
                    kv[k] = ~kv[k];
                    case ($urandom_range(0, 2))
                        0:       rem[k] = $urandom_range(1, 3);
                        1:       rem[k] = $urandom_range(4, 12);
                        default: rem[k] = $urandom_range(18, 45);
                    endcase
                end
                rem[k]--;
            end
            key_n_in = kv;
            if ($urandom_range(0, 699) == 0) apply_reset();
            else tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
